// File: rtl/mtm_alu_serializer.sv
// Serializes an ALU result (4 data frames + control frame) or an error byte (control frame only), 11-bit frames, 1 bit/clk.
// Start bit appears the cycle after valid is accepted; valid is dropped while busy (no queueing, core must hold off).
module mtm_alu_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] C,
  input  logic [7:0]  CTL_out,
  input  logic        valid,
  output logic        sout,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} state_t;

  localparam logic [2:0] CTL_IDX = 3'd4;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] c_reg, c_nxt;
  logic [7:0]  ctl_reg, ctl_nxt;
  logic        sout_nxt, busy_nxt;
  logic [7:0]  payload;

  always_comb begin
    case (byte_cnt)
      3'd0:    payload = c_reg[31:24];
      3'd1:    payload = c_reg[23:16];
      3'd2:    payload = c_reg[15:8];
      3'd3:    payload = c_reg[7:0];
      default: payload = ctl_reg;
    endcase
  end

  // Outputs are computed for the bit that the next state puts on the line,
  // so sout/busy come straight from flops.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    c_nxt        = c_reg;
    ctl_nxt      = ctl_reg;
    sout_nxt     = 1'b1;
    busy_nxt     = 1'b1;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (valid) begin
          c_nxt        = C;
          ctl_nxt      = CTL_out;
          byte_cnt_nxt = CTL_out[7] ? CTL_IDX : 3'd0;
          state_nxt    = START;
          sout_nxt     = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      START: begin
        state_nxt = TYPE;
        sout_nxt  = (byte_cnt == CTL_IDX);
      end
      TYPE: begin
        state_nxt   = DATA;
        bit_cnt_nxt = 3'd7;
        sout_nxt    = payload[7];
      end
      DATA: begin
        if (bit_cnt == 3'd0) begin
          state_nxt = STOP;
          sout_nxt  = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt - 3'd1;
          sout_nxt    = payload[bit_cnt - 3'd1];
        end
      end
      STOP: begin
        if (byte_cnt == CTL_IDX) begin
          state_nxt    = IDLE;
          byte_cnt_nxt = 3'd0;
          busy_nxt     = 1'b0;
        end else begin
          state_nxt    = START;
          byte_cnt_nxt = byte_cnt + 3'd1;
          sout_nxt     = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= 3'd0;
      c_reg    <= 32'd0;
      ctl_reg  <= 8'd0;
      sout     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      c_reg    <= c_nxt;
      ctl_reg  <= ctl_nxt;
      sout     <= sout_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: table of packets with hand-built bit streams plus corner sequences.
module tb_mtm_alu_serializer;

  logic        clk;
  logic        rst_n;
  logic [31:0] C;
  logic [7:0]  CTL_out;
  logic        valid;
  logic        sout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mtm_alu_serializer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .C       (C),
    .CTL_out (CTL_out),
    .valid   (valid),
    .sout    (sout),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  ctl;
    int          len;
    logic [54:0] bits;  // transmit order: bits[len-1] first
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the line idle; returns at the negedge of the idle cycle after the packet.
  task automatic send_pkt(input logic [31:0] c, input logic [7:0] ctl, input int len,
                          input logic [54:0] bits, input int collide_at, input string tag);
    C       = c;
    CTL_out = ctl;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
    C       = $urandom;
    CTL_out = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s sout bit%0d", tag, i), {31'd0, sout}, {31'd0, bits[len-1-i]});
      check($sformatf("%s busy bit%0d", tag, i), {31'd0, busy}, 32'd1);
      if (i == collide_at) begin
        valid   = 1'b1;
        C       = 32'hAAAAAAAA;
        CTL_out = 8'h00;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check($sformatf("%s idle sout", tag), {31'd0, sout}, 32'd1);
    check($sformatf("%s idle busy", tag), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h12345678, 8'h0D, 55,
                {11'b0_0_00010010_1, 11'b0_0_00110100_1, 11'b0_0_01010110_1,
                 11'b0_0_01111000_1, 11'b0_1_00001101_1}};
    vecs[1] = '{32'hFFFFFFFF, 8'hC9, 11, {44'd0, 11'b0_1_11001001_1}};
    vecs[2] = '{32'hDEADBEEF, 8'h7F, 55,
                {11'b0_0_11011110_1, 11'b0_0_10101101_1, 11'b0_0_10111110_1,
                 11'b0_0_11101111_1, 11'b0_1_01111111_1}};
    vecs[3] = '{32'h00000000, 8'h80, 11, {44'd0, 11'b0_1_10000000_1}};

    rst_n   = 1'b1;
    valid   = 1'b0;
    C       = 32'd0;
    CTL_out = 8'd0;
    #1 rst_n = 1'b0;
    #2;
    check("reset sout", {31'd0, sout}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("post-reset idle sout cyc%0d", i), {31'd0, sout}, 32'd1);
      check($sformatf("post-reset idle busy cyc%0d", i), {31'd0, busy}, 32'd0);
    end

    // Each packet is launched in the idle cycle of the previous one: back-to-back.
    for (int v = 0; v < 4; v++)
      send_pkt(vecs[v].c, vecs[v].ctl, vecs[v].len, vecs[v].bits, -1, $sformatf("vec%0d", v));

    // valid during cycle 20 of a normal packet, then during the last stop bit of an error packet.
    send_pkt(vecs[0].c, vecs[0].ctl, vecs[0].len, vecs[0].bits, 19, "collide_mid");
    send_pkt(vecs[1].c, vecs[1].ctl, vecs[1].len, vecs[1].bits, 10, "collide_last");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("after collide sout cyc%0d", i), {31'd0, sout}, 32'd1);
      check($sformatf("after collide busy cyc%0d", i), {31'd0, busy}, 32'd0);
    end

    // Abort during DATA of frame 2 (cycle 16 of the packet).
    C       = 32'h12345678;
    CTL_out = 8'h0D;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (16) @(negedge clk);
    check("pre-abort busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort sout", {31'd0, sout}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("after abort sout cyc%0d", i), {31'd0, sout}, 32'd1);
      check($sformatf("after abort busy cyc%0d", i), {31'd0, busy}, 32'd0);
    end
    send_pkt(32'h0, 8'hA5, 11, {44'd0, 11'b0_1_10100101_1}, -1, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Output stage of the ALU datapath. Takes the 32-bit result word and 8-bit control/status byte produced by the ALU core and transmits them on a single serial line, one bit per clock. Normal results go out as four data frames plus one control frame. Error and status responses go out as the control frame alone.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `C`  in  32  result word from the core.
- `CTL_out`  in  8  control/status byte from the core; bit 7 = 0 means normal result, bit 7 = 1 means error/status only.
- `valid`  in  1  one-cycle strobe: `C`/`CTL_out` are valid this cycle.
- `sout`  out  1  serial output; idles high.
- `busy`  out  1  high while a packet is being transmitted.

## Operation
- Reset (asynchronous, `rst_n` low):
  - `sout`=1, `busy`=0, FSM to IDLE.
  - Bit and byte counters cleared; capture registers cleared.
  - Effective immediately, regardless of clock.
- Capture:
  - At a rising edge with `valid`=1 and FSM in IDLE, register `C` and `CTL_out`.
  - Packet length: 5 frames if captured `CTL_out[7]`=0, otherwise 1 frame.
  - `valid` in any other state is ignored; no queueing.
- Frame format, 11 bits, in transmit order:
  - start bit 0;
  - type bit (0 = data frame, 1 = control frame);
  - 8 payload bits, MSB first;
  - stop bit 1.
- Frame order for a normal packet: `C[31:24]`, `C[23:16]`, `C[15:8]`, `C[7:0]` (all type 0), then the captured `CTL_out` (type 1).
- Error packet: only the captured `CTL_out` frame, type 1.
- FSM states: IDLE, START, TYPE, DATA, STOP.
  - IDLE→START on accepted `valid`.
  - START→TYPE→DATA.
  - DATA holds for 8 cycles (bit counter 7→0), then →STOP.
  - STOP→START if frames remain (byte counter not yet at the last frame).
  - STOP→IDLE after the last frame.
- Frames are back-to-back; there are no idle bits between frames of one packet.
- Byte counter runs 0..4 for normal packets. Error packets start directly at the control-frame index.

## Timing
- Edge E: `valid` is accepted.
- Cycle after E: `sout` carries the start bit (0) and `busy` is 1. Both are registered outputs.
- Each frame occupies exactly 11 consecutive clock cycles.
- Packet duration: 55 cycles for a normal packet, 11 cycles for an error packet.
- `busy` is high for exactly 55 (or 11) cycles and drops in the cycle after the last stop bit. `sout` is 1 in that cycle.
- Turnaround: a `valid` at the first edge where `busy`=0 is accepted. The next start bit immediately follows that idle-high cycle, giving a minimum 1-cycle gap between packets.
- `valid` while `busy`=1, including the edge on which the last stop bit is driven, is dropped. The core must hold off.
- Reset asserted mid-packet aborts the packet: `sout` is forced to 1 at once and no partial frame resumes after reset release.
- Inputs `C`/`CTL_out` may change freely after capture; the transmitted data comes only from the registers.

## Test plan
- Reset values: hold `rst_n`=0 → `sout`=1, `busy`=0. Release with `valid`=0 for 20 cycles → `sout` stays 1.
- Normal packet: `C`=0x12345678, `CTL_out`=0x0D, `valid` pulse → 55 bits starting the next cycle:
  - 0 0 00010010 1;
  - 0 0 00110100 1;
  - 0 0 01010110 1;
  - 0 0 01111000 1;
  - 0 1 00001101 1;
  - then `busy` falls.
- Error packet: `CTL_out`=0xC9, `C`=0xFFFFFFFF → exactly 11 bits 0 1 11001001 1. `busy` high for 11 cycles. No data frames.
- Busy collision: second `valid` with `C`=0xAAAAAAAA at cycle 20 of a packet → ignored; the first packet completes unchanged and `sout` then stays 1.
- Reset mid-frame: assert `rst_n`=0 during the DATA phase of frame 2 → `sout`=1 and `busy`=0 asynchronously. After release plus a new `valid` with `CTL_out`=0xA5 → one clean frame 0 1 10100101 1.
- Back-to-back: `valid` on the first edge with `busy`=0 after a packet → accepted; exactly one idle-high cycle appears before the new start bit.
